// File: rtl/tl_pkg.sv
// Shared state encodings, lamp codes and head decode for the intersection controller.
package tl_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    WALK  = 3'd6
  } tl_state_e;

  // Lamp heads are active-low {red,yellow,green}
  localparam logic [2:0] RED    = 3'b011;
  localparam logic [2:0] YELLOW = 3'b101;
  localparam logic [2:0] GREEN  = 3'b110;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } heads_t;

  // Each state lights at most one head non-RED, so the heads can never conflict.
  function automatic heads_t decode_heads(input tl_state_e s);
    heads_t h;
    h.ns = RED;
    h.ew = RED;
    case (s)
      NS_G:    h.ns = GREEN;
      NS_Y:    h.ns = YELLOW;
      EW_G:    h.ew = GREEN;
      EW_Y:    h.ew = YELLOW;
      default: ;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick once every CLK_HZ clocks.
module tick_gen #(
  parameter int CLK_HZ = 27_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_HZ - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way traffic light controller with optional pedestrian walk phase.
// Define PED_WALK_EN to build the pedestrian synchronizer, request latch and WALK state.
module intersection_ctrl
  import tl_pkg::*;
#(
  parameter int CLK_HZ   = 27_000_000,
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 2,
  parameter int ALLRED_S = 1,
  parameter int WALK_S   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  output logic [2:0] led_ns,
  output logic [2:0] led_ew,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  localparam int SW = 16;

  tl_state_e st, nxt;
  logic [SW-1:0] sec;
  logic tick, done, ped_go, next_dir;
  heads_t heads;

  function automatic logic [SW-1:0] dur_m1(input tl_state_e s);
    case (s)
      NS_G, EW_G: return SW'(GREEN_S - 1);
      NS_Y, EW_Y: return SW'(YELLOW_S - 1);
      WALK:       return SW'(WALK_S - 1);
      default:    return SW'(ALLRED_S - 1);
    endcase
  endfunction

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign done = tick && (sec == dur_m1(st));

  always_comb begin
    nxt = st;
    case (st)
      NS_G:    nxt = NS_Y;
      NS_Y:    nxt = RED_A;
      RED_A:   nxt = ped_go ? WALK : EW_G;
      EW_G:    nxt = EW_Y;
      EW_Y:    nxt = RED_B;
      RED_B:   nxt = ped_go ? WALK : NS_G;
      WALK:    nxt = (next_dir == DIR_EW) ? EW_G : NS_G;
      default: nxt = RED_B;
    endcase
  end

  // Seconds counter restarts on every state entry; reset lands in RED_B for a full clearance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= RED_B;
      sec <= '0;
    end else if (done) begin
      st  <= nxt;
      sec <= '0;
    end else if (tick) begin
      sec <= sec + 1'b1;
    end
  end

`ifdef PED_WALK_EN
  // sync[0..1] resynchronize the button, sync[2] holds the previous level for edge detect
  logic [2:0] sync;
  logic ped_edge, pend, dir_r;

  assign ped_edge = sync[1] & ~sync[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      pend  <= 1'b0;
      dir_r <= DIR_NS;
    end else begin
      sync <= {sync[1:0], ped_req};
      // A new press landing on the WALK entry cycle is kept for the next service.
      if (done && nxt == WALK) begin
        pend  <= ped_edge;
        dir_r <= (st == RED_A) ? DIR_EW : DIR_NS;
      end else if (ped_edge) begin
        pend <= 1'b1;
      end
    end
  end

  assign ped_go      = pend;
  assign ped_pending = pend;
  assign next_dir    = dir_r;
  assign walk        = (st == WALK);
`else
  logic unused_ped;
  assign unused_ped  = ped_req;
  assign ped_go      = 1'b0;
  assign ped_pending = 1'b0;
  assign next_dir    = DIR_NS;
  assign walk        = 1'b0;
`endif

  assign heads  = decode_heads(st);
  assign led_ns = heads.ns;
  assign led_ew = heads.ew;
  assign state  = st;

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27_000_000, clock cycles per second.
REQ-002 SHALL have parameter GREEN_S, default 10, green duration in seconds (>=1).
REQ-003 SHALL have parameter YELLOW_S, default 2, yellow duration in seconds (>=1).
REQ-004 SHALL have parameter ALLRED_S, default 1, all-red clearance duration in seconds (>=1).
REQ-005 SHALL have parameter WALK_S, default 5, pedestrian walk duration in seconds (>=1).
REQ-006 SHALL have port clk  input  1  system clock; single clock domain.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port ped_req  input  1  pedestrian button, asynchronous to clk, active-high.
REQ-009 SHALL have port led_ns  output  3  north-south head, active-low {red,yellow,green}.
REQ-010 SHALL have port led_ew  output  3  east-west head, active-low {red,yellow,green}.
REQ-011 SHALL have port walk  output  1  pedestrian walk lamp, active-high.
REQ-012 SHALL have port ped_pending  output  1  latched pedestrian request awaiting service.
REQ-013 SHALL have port state  output  3  current FSM state, for debug.

Function
REQ-014 SHALL use lamp codes RED=3'b011, YELLOW=3'b101, GREEN=3'b110.
REQ-015 SHALL run a prescaler 0..CLK_HZ-1 that wraps to 0; tick is high for the one cycle in which the count equals CLK_HZ-1.
REQ-016 SHALL clear the seconds counter on every state entry; on tick, it SHALL advance state when sec == duration-1, else increment.
REQ-017 SHALL implement states NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5, WALK=6.
REQ-018 SHALL sequence NS_G(GREEN_S) -> NS_Y(YELLOW_S) -> RED_A(ALLRED_S) -> EW_G -> EW_Y -> RED_B -> NS_G.
REQ-019 SHALL, on leaving RED_A or RED_B with ped_pending=1, enter WALK(WALK_S) and then proceed to the green that RED_A/RED_B would have entered; a next_dir bit SHALL hold that direction.
REQ-020 SHALL decode outputs from the state register with no extra latency: the green head shows GREEN, the yellow head shows YELLOW, all other heads show RED; walk=1 only in WALK.
REQ-021 SHALL never drive led_ns and led_ew both non-RED in the same cycle.
REQ-022 SHALL pass ped_req through a 2-flop synchronizer and a rising-edge detector; a detected edge sets ped_pending.
REQ-023 SHALL clear ped_pending on WALK entry; an edge detected in that same cycle SHALL leave ped_pending set.
REQ-024 SHALL ignore a held-high ped_req after its first edge (level does not retrigger).

Reset
REQ-025 SHALL, while rst=1 and independent of clk, force: state=RED_B, next_dir=NS, prescaler=0, sec=0, ped_pending=0, synchronizer flops=0, led_ns=led_ew=RED, walk=0.
REQ-026 SHALL, on reset mid-operation, abandon the current phase immediately; after release it SHALL restart from RED_B with a full ALLRED_S.

Configuration
REQ-027 SHALL, with PED_WALK_EN defined, include the synchronizer, ped_pending, the WALK state and walk output as specified.
REQ-028 SHALL, with PED_WALK_EN undefined, ignore ped_req, tie walk=0 and ped_pending=0, and go directly RED_A->EW_G and RED_B->NS_G.

Structure
REQ-029 SHALL take the state encodings and the lamp constants RED/YELLOW/GREEN from shared package tl_pkg.
REQ-030 SHALL place the prescaler in sub-module tick_gen (parameter CLK_HZ; ports clk, rst, tick).

Verification
REQ-031 SHALL cover: CLK_HZ=4, GREEN_S=3, YELLOW_S=1, ALLRED_S=1 after reset -> both RED for 4 cycles, then led_ns GREEN 12, YELLOW 4, all-RED 4, led_ew GREEN 12 cycles.
REQ-032 SHALL cover: 1-cycle ped_req pulse during NS_G -> ped_pending=1 within 3 cycles; after RED_A, walk=1 for WALK_S*4 cycles with both heads RED and ped_pending=0; then EW_G.
REQ-033 SHALL cover: ped_req held high for 100 cycles -> exactly one WALK phase served.
REQ-034 SHALL cover: rst asserted mid EW_G between clk edges -> led_ns=led_ew=3'b011 and walk=0 immediately.
REQ-035 SHALL cover: PED_WALK_EN undefined with ped_req toggling -> walk stays 0 and the sequence is identical to REQ-031.
REQ-036 SHALL cover: an assertion over all runs that led_ns and led_ew are never both non-RED.
